uart_rx_word_packer: RTL and testbench
======================================

Name: uart_rx_word_packer

Overview:
- Sits between the UART receiver and the SRAM loader/controller.
- Consumes the receiver's byte stream (rx_data_out / rx_valid) and assembles bytes little-endian into 32-bit words.
- Buffers completed words in a small FIFO and presents them to the downstream consumer over a ready/valid handshake.
- Drops stale partial words after an inter-byte timeout and reports drops, overflows and a running word count.

Parameters:
- FIFO_DEPTH, 2, number of 32-bit word entries; power of two, >= 2.
- TIMEOUT_CYCLES, 50000, clk cycles without a new byte before a partial word is discarded; >= 2.
- CNT_W, 16, width of the word counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- enable  input  1  packer enable; connects to the receiver's enable
- rx_data  input  8  byte from the UART receiver
- rx_valid  input  1  byte strobe from the receiver, one cycle per byte
- rx_ready  output  1  packer can accept a byte; drives the receiver's ready
- word_data  output  32  FIFO head word
- word_valid  output  1  FIFO not empty
- word_ready  input  1  consumer accepts the head word
- partial_drop  output  1  one-cycle pulse when a timeout discards a partial word
- overflow  output  1  sticky: a byte arrived while rx_ready was low
- clear_flags  input  1  clears overflow
- word_count  output  CNT_W  number of words pushed since reset; wraps

Behaviour:
- Reset (rst_n=0 at a clk edge): the following outputs are 0 — rx_ready, word_valid, partial_drop, overflow, word_count. FIFO is empty, byte index is 0, timeout counter is 0, assembly register is 0. word_data = 0 while empty.
- Byte accept: occurs when rx_valid & rx_ready at an edge.
  - Byte k (k = 0..3) goes to assembly bits [8k+7:8k].
  - Byte index increments, wrapping 3 -> 0.
- Word push:
  - On accepting byte 3, the word {b3,b2,b1,b0} is written into the FIFO at that same edge.
  - word_count increments at that edge.
  - word_valid is high in the following cycle. Latency is 1 cycle from the last byte's edge.
- rx_ready = enable & rst_n & !fifo_full, combinational from registered state.
  - There is no bypass: a pop in the same cycle does not raise rx_ready.
- FIFO:
  - word_data is the head entry; word_valid = !empty.
  - Pop occurs when word_valid & word_ready.
  - Push and pop in the same edge are both permitted when neither full nor empty blocks them. Occupancy is unchanged.
  - When empty, word_ready is ignored.
- Overflow: rx_valid & !rx_ready & enable sets overflow.
  - The byte is discarded; byte index and assembly register are unchanged.
  - clear_flags clears overflow. A set and a clear in the same cycle results in overflow = 1.
- Timeout:
  - The counter runs only while byte index != 0, and resets to 0 on every accepted byte.
  - When the counter reaches TIMEOUT_CYCLES-1: byte index -> 0, counter -> 0, and partial_drop pulses high for exactly 1 cycle.
  - If a byte is accepted in that same cycle, the byte wins: it is accepted, the counter resets, and there is no drop.
- enable low:
  - rx_ready = 0.
  - The partial word is discarded silently (byte index -> 0, no partial_drop).
  - The timeout counter is held at 0.
  - FIFO contents remain and still drain.
  - overflow is not set while enable is low.
- Reset mid-word or mid-drain: all state is cleared at the next edge and buffered words are lost.
- word_count wraps from 2^CNT_W-1 to 0.

Decomposition:
- Shared package uart_pkg:
  - BYTE_W = 8
  - WORD_W = 32
  - BYTES_PER_WORD = 4
  - default TIMEOUT_CYCLES constant
- Sub-module sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports: clk, rst_n, push, din, full, pop, dout, empty.
  - Registered storage, one-cycle write-to-read visibility.
- Top: the byte assembler, timeout counter and flags.

Test Plan:
- Send bytes 0x78, 0x56, 0x34, 0x12 with word_ready=1 -> word_valid pulses one cycle after the 4th byte, word_data = 0x12345678, word_count = 1.
- word_ready=0; send 12 bytes 0x00..0x0B -> rx_ready drops after 8 bytes (FIFO_DEPTH=2). Bytes 0x08..0x0B set overflow. Raising word_ready then pops 0x03020100 then 0x07060504. clear_flags then returns overflow to 0.
- Send 2 bytes then idle TIMEOUT_CYCLES cycles -> partial_drop pulses exactly once. Then bytes AA, BB, CC, DD -> word 0xDDCCBBAA, word_count unchanged by the drop.
- A byte arrives in the exact cycle the timeout fires -> no partial_drop; the word completes normally with that byte in its position.
- Deassert enable after 3 bytes while 1 word is buffered -> rx_ready = 0 and the buffered word still pops. Re-enable; 4 new bytes form a clean word with no stale bytes.
- Assert rst_n=0 for one cycle mid-word with a full FIFO -> the next cycle has word_valid=0, word_count=0, overflow=0, and rx_ready=1 once enable is high.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: byte/word geometry and the
// default inter-byte timeout.
package uart_pkg;

  localparam int BYTE_W                 = 8;
  localparam int WORD_W                 = 32;
  localparam int BYTES_PER_WORD         = WORD_W / BYTE_W;
  localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; a pushed entry is visible at
// dout one cycle after the push edge. dout reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_word_packer.sv
// Packs the UART receiver's byte stream little-endian into 32-bit words,
// buffers them for a ready/valid consumer, and drops stale partial words.
module uart_rx_word_packer
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              partial_drop,
  output logic              overflow,
  input  logic              clear_flags,
  output logic [CNT_W-1:0]  word_count
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam int ASM_W = (BYTES_PER_WORD - 1) * BYTE_W;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [IDX_W-1:0]  byte_idx;
  logic [ASM_W-1:0]  asm_q;
  logic [TO_W-1:0]   to_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              push;
  logic              pop;
  logic              to_hit;
  logic              ovf_set;
  logic [WORD_W-1:0] word;

  assign rx_ready   = enable & rst_n & ~fifo_full;
  assign accept     = rx_valid & rx_ready;
  assign push       = accept & (byte_idx == LAST_IDX);
  assign word_valid = ~fifo_empty;
  assign pop        = word_valid & word_ready;
  assign to_hit     = (byte_idx != '0) && (to_cnt == TO_LAST);
  assign ovf_set    = rx_valid & ~rx_ready & enable;
  // The final byte goes straight into the FIFO; only the lower lanes are held.
  assign word       = {rx_data, asm_q};

  // An accepted byte always beats a timeout or an enable drop in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_idx     <= '0;
      asm_q        <= '0;
      to_cnt       <= '0;
      partial_drop <= 1'b0;
      overflow     <= 1'b0;
      word_count   <= '0;
    end else begin
      partial_drop <= 1'b0;
      if (accept) begin
        for (int k = 0; k < BYTES_PER_WORD - 1; k++) begin
          if (byte_idx == IDX_W'(k)) asm_q[k*BYTE_W +: BYTE_W] <= rx_data;
        end
        byte_idx <= byte_idx + IDX_ONE;
        to_cnt   <= '0;
      end else if (!enable) begin
        byte_idx <= '0;
        to_cnt   <= '0;
      end else if (byte_idx != '0) begin
        if (to_hit) begin
          byte_idx     <= '0;
          to_cnt       <= '0;
          partial_drop <= 1'b1;
        end else begin
          to_cnt <= to_cnt + TO_ONE;
        end
      end
      if (push) word_count <= word_count + CNT_ONE;
      overflow <= ovf_set | (overflow & ~clear_flags);
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (word),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (word_data),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Bench for uart_rx_word_packer: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based model.
module tb_uart_rx_word_packer;

  localparam int DEPTH = 2;
  localparam int TO    = 20;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [31:0]   word_data;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic          partial_drop;
  logic          overflow;
  logic          clear_flags = 1'b0;
  logic [CW-1:0] word_count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  uart_rx_word_packer #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .partial_drop (partial_drop),
    .overflow     (overflow),
    .clear_flags  (clear_flags),
    .word_count   (word_count)
  );

  // Reference model: pending bytes and buffered words as plain queues,
  // idle counted as clock edges since the last accepted byte.
  logic [7:0]  pend[$];
  logic [31:0] mq[$];
  int          idle  = 0;
  bit          m_ovf = 1'b0;
  bit          m_drop = 1'b0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    bit rdy;
    bit acc;
    if (!rst_n) begin
      pend.delete();
      mq.delete();
      idle   = 0;
      m_ovf  = 1'b0;
      m_drop = 1'b0;
      m_cnt  = 0;
    end else begin
      rdy    = enable && (mq.size() < DEPTH);
      acc    = rx_valid && rdy;
      m_ovf  = (rx_valid && !rdy && enable) || (m_ovf && !clear_flags);
      m_drop = 1'b0;
      if (word_ready && mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        pend.push_back(rx_data);
        idle = 0;
        if (pend.size() == 4) begin
          mq.push_back({pend[3], pend[2], pend[1], pend[0]});
          m_cnt = (m_cnt + 1) % (1 << CW);
          pend.delete();
        end
      end else if (!enable) begin
        pend.delete();
        idle = 0;
      end else if (pend.size() > 0) begin
        idle++;
        if (idle >= TO) begin
          pend.delete();
          idle   = 0;
          m_drop = 1'b1;
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("rx_ready", 32'(rx_ready), 32'(enable && rst_n && (mq.size() < DEPTH)));
      cmp("word_valid", 32'(word_valid), 32'(mq.size() > 0));
      cmp("word_data", word_data, (mq.size() > 0) ? mq[0] : 32'h0);
      cmp("partial_drop", 32'(partial_drop), 32'(m_drop));
      cmp("overflow", 32'(overflow), 32'(m_ovf));
      cmp("word_count", 32'(word_count), 32'(m_cnt));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic look;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    int drops;
    int burst;
    enable     = 1'b1;
    word_ready = 1'b1;
    tick();
    chk_en = 1'b1;
    look();
    cmp("rst_rx_ready", 32'(rx_ready), 32'h0);
    cmp("rst_word_valid", 32'(word_valid), 32'h0);
    cmp("rst_word_count", 32'(word_count), 32'h0);
    cmp("rst_overflow", 32'(overflow), 32'h0);
    cmp("rst_word_data", word_data, 32'h0);
    tick();
    rst_n = 1'b1;
    look();
    cmp("idle_rx_ready", 32'(rx_ready), 32'h1);

    // Basic word assembly
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    look();
    cmp("w1_valid", 32'(word_valid), 32'h1);
    cmp("w1_data", word_data, 32'h12345678);
    cmp("w1_count", 32'(word_count), 32'h1);
    tick();
    look();
    cmp("w1_popped", 32'(word_valid), 32'h0);

    // Fill FIFO, overflow, drain, clear
    word_ready = 1'b0;
    for (int i = 0; i < 12; i++) send_byte(8'(i));
    look();
    cmp("full_rx_ready", 32'(rx_ready), 32'h0);
    cmp("full_overflow", 32'(overflow), 32'h1);
    cmp("full_count", 32'(word_count), 32'h3);
    cmp("full_head", word_data, 32'h03020100);
    word_ready = 1'b1;
    tick();
    look();
    cmp("drain_second", word_data, 32'h07060504);
    tick();
    look();
    cmp("drain_empty", 32'(word_valid), 32'h0);
    cmp("ovf_still_set", 32'(overflow), 32'h1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    look();
    cmp("ovf_cleared", 32'(overflow), 32'h0);

    // Timeout discards a partial word exactly once
    send_byte(8'h01); send_byte(8'h02);
    drops = 0;
    for (int i = 0; i < TO + 5; i++) begin
      look();
      if (partial_drop) drops++;
      tick();
    end
    cmp("drop_once", 32'(drops), 32'h1);
    cmp("drop_count", 32'(word_count), 32'h3);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    look();
    cmp("after_drop_word", word_data, 32'hDDCCBBAA);
    cmp("after_drop_count", 32'(word_count), 32'h4);
    tick();

    // Byte arriving on the exact timeout edge wins
    send_byte(8'h11); send_byte(8'h22);
    drops = 0;
    for (int i = 0; i < TO - 1; i++) begin
      look();
      if (partial_drop) drops++;
      tick();
    end
    send_byte(8'h33);
    look();
    if (partial_drop) drops++;
    cmp("race_no_drop", 32'(drops), 32'h0);
    send_byte(8'h44);
    look();
    cmp("race_word", word_data, 32'h44332211);
    cmp("race_count", 32'(word_count), 32'h5);
    tick();

    // Enable low discards the partial word but the FIFO still drains
    word_ready = 1'b0;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    enable = 1'b0;
    look();
    cmp("dis_rx_ready", 32'(rx_ready), 32'h0);
    cmp("dis_head", word_data, 32'h04030201);
    send_byte(8'hFF);
    look();
    cmp("dis_no_ovf", 32'(overflow), 32'h0);
    word_ready = 1'b1;
    tick();
    look();
    cmp("dis_drained", 32'(word_valid), 32'h0);
    enable = 1'b1;
    send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3); send_byte(8'hB4);
    look();
    cmp("reen_word", word_data, 32'hB4B3B2B1);
    cmp("reen_count", 32'(word_count), 32'h7);
    tick();

    // Reset with a full FIFO and overflow pending
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'h50 + 8'(i));
    send_byte(8'hEE);
    look();
    cmp("pre_rst_ovf", 32'(overflow), 32'h1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    look();
    cmp("mid_rst_valid", 32'(word_valid), 32'h0);
    cmp("mid_rst_count", 32'(word_count), 32'h0);
    cmp("mid_rst_ovf", 32'(overflow), 32'h0);
    cmp("mid_rst_ready", 32'(rx_ready), 32'h1);
    tick();

    // Randomized traffic
    burst = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (burst > 0) begin
        rx_valid = 1'b0;
        burst--;
      end else begin
        if ($urandom_range(0, 99) < 3) burst = $urandom_range(TO - 3, TO + 3);
        rx_valid = ($urandom_range(0, 1) == 1);
        rx_data  = 8'($urandom);
      end
      word_ready  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      clear_flags = ($urandom_range(0, 19) == 0);
      rst_n       = ($urandom_range(0, 999) != 0);
      tick();
    end
    rx_valid    = 1'b0;
    clear_flags = 1'b0;
    rst_n       = 1'b1;
    tick();
    look();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
